// File: rtl/alu_ctrl_exec.sv
// alu_ctrl_exec: EX-stage ALU with registered ALU-control decode.
// Decodes ALUOp plus instruction[31:21] into a 4-bit ALU code and executes the
// operation on WIDTH-bit operands. Single-cycle ops have latency 1 and full
// throughput. MUL is an iterative shift-add over WIDTH cycles.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   alu_op, opcode        ALUOp and instruction[31:21]
//   op_a, op_b            operands (Rn, Rm or immediate)
//   out_valid / out_ready output handshake
//   result, zero          held result and its zero flag
//   alu_code, illegal     decoded code of the held result, undecodable flag
//   busy                  multiply in progress
module alu_ctrl_exec #(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [10:0]      opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [3:0]       alu_code,
  output logic             illegal,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_ORR = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_PSB = 4'b0111;
  localparam logic [3:0] C_MUL = 4'b1000;
  localparam logic [3:0] C_ILL = 4'b1111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
  logic [CW-1:0]    cnt;
  logic [3:0]       dec_code;
  logic [WIDTH-1:0] sc_res;
  logic             accept;

  // Decode: first match wins; alu_op=11 falls into the PASS_B arm.
  always_comb begin
    dec_code = C_ILL;
    if (alu_op == 2'b00)  dec_code = C_ADD;
    else if (alu_op[0])   dec_code = C_PSB;
    else begin
      case (opcode)
        11'b10001011000: dec_code = C_ADD;
        11'b11001011000: dec_code = C_SUB;
        11'b10001010000: dec_code = C_AND;
        11'b10101010000: dec_code = C_ORR;
        11'b10011011000: dec_code = MUL_EN ? C_MUL : C_ILL;
        default:         dec_code = C_ILL;
      endcase
    end
  end

  // Single-cycle datapath; MUL and ILLEGAL produce 0 here (MUL never uses it).
  always_comb begin
    sc_res = '0;
    case (dec_code)
      C_ADD:   sc_res = op_a + op_b;
      C_SUB:   sc_res = op_a - op_b;
      C_AND:   sc_res = op_a & op_b;
      C_ORR:   sc_res = op_a | op_b;
      C_PSB:   sc_res = op_b;
      default: sc_res = '0;
    endcase
  end

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      illegal   <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      alu_code  <= 4'b0000;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (dec_code == C_MUL) begin
              // Previous result (if any) is consumed on this edge; output
              // stays empty until the multiply finishes.
              mcand     <= op_a;
              mplier    <= op_b;
              acc       <= '0;
              cnt       <= '0;
              busy      <= 1'b1;
              out_valid <= 1'b0;
              state     <= MUL;
            end else begin
              result    <= sc_res;
              zero      <= (sc_res == '0);
              alu_code  <= dec_code;
              illegal   <= (dec_code == C_ILL);
              out_valid <= 1'b1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          // Fixed WIDTH iterations, no early exit on a zero multiplier.
          if (cnt == CW'(WIDTH - 1)) begin
            result    <= acc_next;
            zero      <= (acc_next == '0);
            alu_code  <= C_MUL;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_exec.sv
module tb_alu_ctrl_exec;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_MUL = 11'b10011011000;
  localparam logic [10:0] OP_BAD = 11'b11111111111;

  typedef struct packed {
    logic [63:0] res;
    logic [3:0]  code;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iv_a = 1'b0, iv_b = 1'b0, iv_c = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  alu_op = 2'b00;
  logic [10:0] opcode = '0;
  logic [63:0] op_a = '0, op_b = '0;

  logic        ir_a, ov_a, z_a, ill_a, busy_a;
  logic [63:0] res_a;
  logic [3:0]  code_a;
  logic        ir_b, ov_b, z_b, ill_b, busy_b;
  logic [7:0]  res_b;
  logic [3:0]  code_b;
  logic        ir_c, ov_c, z_c, ill_c, busy_c;
  logic [63:0] res_c;
  logic [3:0]  code_c;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  alu_ctrl_exec #(.WIDTH(64), .MUL_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .alu_op(alu_op),
    .opcode(opcode), .op_a(op_a), .op_b(op_b), .out_valid(ov_a),
    .out_ready(out_ready), .result(res_a), .zero(z_a), .alu_code(code_a),
    .illegal(ill_a), .busy(busy_a));

  alu_ctrl_exec #(.WIDTH(8), .MUL_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .alu_op(alu_op),
    .opcode(opcode), .op_a(op_a[7:0]), .op_b(op_b[7:0]), .out_valid(ov_b),
    .out_ready(out_ready), .result(res_b), .zero(z_b), .alu_code(code_b),
    .illegal(ill_b), .busy(busy_b));

  alu_ctrl_exec #(.WIDTH(64), .MUL_EN(1'b0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(ir_c), .alu_op(alu_op),
    .opcode(opcode), .op_a(op_a), .op_b(op_b), .out_valid(ov_c),
    .out_ready(out_ready), .result(res_c), .zero(z_c), .alu_code(code_c),
    .illegal(ill_c), .busy(busy_c));

  // Reference: what the operation means, straight from the decode table.
  function automatic exp_t model(input logic [1:0] aop, input logic [10:0] opc,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input int w, input bit mul_en);
    exp_t e;
    logic [63:0] mask;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    e.ill = 1'b0;
    if (aop == 2'b00) begin e.code = 4'b0010; e.res = a + b; end
    else if (aop == 2'b01 || aop == 2'b11) begin e.code = 4'b0111; e.res = b; end
    else if (opc == OP_ADD) begin e.code = 4'b0010; e.res = a + b; end
    else if (opc == OP_SUB) begin e.code = 4'b0110; e.res = a - b; end
    else if (opc == OP_AND) begin e.code = 4'b0000; e.res = a & b; end
    else if (opc == OP_ORR) begin e.code = 4'b0001; e.res = a | b; end
    else if (opc == OP_MUL && mul_en) begin e.code = 4'b1000; e.res = a * b; end
    else begin e.code = 4'b1111; e.res = 64'd0; e.ill = 1'b1; end
    e.res = e.res & mask;
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    iv_a = 0; iv_b = 0; iv_c = 0; out_ready = 1;
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    logic seen;
    @(negedge clk);
    rst = 1;
    #1;
    total++; if (ov_a !== 1'b0 || z_a !== 1'b1 || ir_a !== 1'b1 || busy_a !== 1'b0 ||
                 res_a !== 64'd0 || code_a !== 4'b0000 || ill_a !== 1'b0)
      $display("FAIL reset_state: ov=%b z=%b ir=%b busy=%b res=%h code=%b ill=%b want 0 1 1 0 0 0000 0",
               ov_a, z_a, ir_a, busy_a, res_a, code_a, ill_a);
    else pass_cnt++;
    @(negedge clk);
    rst = 0;
    // Start a 64-bit MUL, then reset during iteration 10.
    alu_op = 2'b10; opcode = OP_MUL; op_a = 64'd3; op_b = 64'd5; iv_a = 1;
    @(negedge clk);
    iv_a = 0;
    repeat (9) @(negedge clk);
    total++; if (busy_a !== 1'b1) $display("FAIL mul_busy_before_rst: got %b want 1", busy_a);
    else pass_cnt++;
    #2 rst = 1;
    #1;
    total++; if (busy_a !== 1'b0 || ov_a !== 1'b0)
      $display("FAIL rst_mid_mul: busy=%b ov=%b want 0 0", busy_a, ov_a);
    else pass_cnt++;
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (ov_a || busy_a) seen = 1;
    end
    total++; if (seen !== 1'b0) $display("FAIL rst_aborts_mul: output appeared, got 1 want 0");
    else pass_cnt++;
  endtask

  task automatic test_sub();
    do_reset();
    alu_op = 2'b10; opcode = OP_SUB; op_a = 64'd5; op_b = 64'd7; iv_a = 1;
    @(negedge clk);
    op_a = 64'h1234; op_b = 64'h1234;
    total++; if (ov_a !== 1'b1 || res_a !== 64'hFFFF_FFFF_FFFF_FFFE || code_a !== 4'b0110 ||
                 z_a !== 1'b0 || ill_a !== 1'b0)
      $display("FAIL sub_wrap: ov=%b res=%h code=%b z=%b ill=%b want 1 fffffffffffffffe 0110 0 0",
               ov_a, res_a, code_a, z_a, ill_a);
    else pass_cnt++;
    @(negedge clk);
    iv_a = 0;
    total++; if (ov_a !== 1'b1 || res_a !== 64'd0 || z_a !== 1'b1)
      $display("FAIL sub_zero: ov=%b res=%h z=%b want 1 0 1", ov_a, res_a, z_a);
    else pass_cnt++;
    @(negedge clk);
    total++; if (ov_a !== 1'b0) $display("FAIL sub_drain: ov=%b want 0", ov_a);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [1:0]  aops [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10};
    logic [10:0] opcs [5] = '{OP_BAD, OP_BAD, OP_SUB, OP_AND, OP_ORR};
    logic [63:0] as [5];
    logic [63:0] bs [5];
    logic [3:0]  codes [5] = '{4'b0010, 4'b0111, 4'b0111, 4'b0000, 4'b0001};
    logic [63:0] exp_r [5];
    for (int i = 0; i < 3; i++) begin
      as[i] = {$urandom, $urandom}; bs[i] = {$urandom, $urandom};
    end
    as[3] = 64'hF0F0; bs[3] = 64'hFF00; as[4] = 64'hF0F0; bs[4] = 64'hFF00;
    exp_r[0] = as[0] + bs[0]; exp_r[1] = bs[1]; exp_r[2] = bs[2];
    exp_r[3] = 64'hF000; exp_r[4] = 64'hFFF0;
    do_reset();
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) begin
        total++; if (ov_a !== 1'b1 || res_a !== exp_r[i-1] || code_a !== codes[i-1] ||
                     ir_a !== 1'b1)
          $display("FAIL b2b_%0d: ov=%b res=%h code=%b ir=%b want 1 %h %b 1",
                   i-1, ov_a, res_a, code_a, ir_a, exp_r[i-1], codes[i-1]);
        else pass_cnt++;
      end
      if (i < 5) begin
        alu_op = aops[i]; opcode = opcs[i]; op_a = as[i]; op_b = bs[i]; iv_a = 1;
      end else iv_a = 0;
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    alu_op = 2'b10; opcode = OP_BAD; op_a = 64'd9; op_b = 64'd4; iv_a = 1;
    @(negedge clk);
    iv_a = 0;
    total++; if (ov_a !== 1 || res_a !== 64'd0 || code_a !== 4'b1111 || ill_a !== 1 || z_a !== 1)
      $display("FAIL illegal_opc: ov=%b res=%h code=%b ill=%b z=%b want 1 0 1111 1 1",
               ov_a, res_a, code_a, ill_a, z_a);
    else pass_cnt++;
    opcode = OP_MUL; op_a = 64'd6; op_b = 64'd7; iv_c = 1;
    @(negedge clk);
    iv_c = 0;
    total++; if (ov_c !== 1 || res_c !== 64'd0 || code_c !== 4'b1111 || ill_c !== 1 ||
                 z_c !== 1 || busy_c !== 0)
      $display("FAIL mul_disabled: ov=%b res=%h code=%b ill=%b z=%b busy=%b want 1 0 1111 1 1 0",
               ov_c, res_c, code_c, ill_c, z_c, busy_c);
    else pass_cnt++;
  endtask

  task automatic test_mul8();
    logic bad;
    do_reset();
    alu_op = 2'b10; opcode = OP_MUL; op_a = 64'h13; op_b = 64'h0F; iv_b = 1;
    @(negedge clk);
    // Offer an ADD while the multiply runs; it must wait.
    opcode = OP_ADD; op_a = 64'h20; op_b = 64'h03;
    bad = 0;
    for (int k = 1; k <= 7; k++) begin
      if (ov_b !== 0 || busy_b !== 1 || ir_b !== 0) bad = 1;
      @(negedge clk);
    end
    total++; if (bad) $display("FAIL mul8_busy: out_valid/busy/in_ready wrong during multiply, got bad=1 want 0");
    else pass_cnt++;
    total++; if (ov_b !== 0 || busy_b !== 1) $display("FAIL mul8_cycle8: ov=%b busy=%b want 0 1", ov_b, busy_b);
    else pass_cnt++;
    @(negedge clk);
    total++; if (ov_b !== 1 || res_b !== 8'h1D || code_b !== 4'b1000 || busy_b !== 0 || ill_b !== 0)
      $display("FAIL mul8_result: ov=%b res=%h code=%b busy=%b ill=%b want 1 1d 1000 0 0",
               ov_b, res_b, code_b, busy_b, ill_b);
    else pass_cnt++;
    @(negedge clk);
    iv_b = 0;
    total++; if (ov_b !== 1 || res_b !== 8'h23 || code_b !== 4'b0010)
      $display("FAIL mul8_followup_add: ov=%b res=%h code=%b want 1 23 0010", ov_b, res_b, code_b);
    else pass_cnt++;
    @(negedge clk);
    total++; if (ov_b !== 0) $display("FAIL mul8_drain: ov=%b want 0", ov_b);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic bad;
    do_reset();
    out_ready = 0;
    alu_op = 2'b00; opcode = OP_BAD; op_a = 64'd100; op_b = 64'd23; iv_a = 1;
    @(negedge clk);
    iv_a = 0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        alu_op = 2'b10; opcode = OP_SUB; op_a = 64'd50; op_b = 64'd8; iv_a = 1;
      end
      #1;
      if (ov_a !== 1 || res_a !== 64'd123 || code_a !== 4'b0010 || z_a !== 0 || ir_a !== 0) bad = 1;
      @(negedge clk);
    end
    total++; if (bad) $display("FAIL bp_hold: held output or in_ready changed, got bad=1 want 0");
    else pass_cnt++;
    out_ready = 1;
    #1;
    total++; if (ir_a !== 1) $display("FAIL bp_release_ready: ir=%b want 1", ir_a);
    else pass_cnt++;
    @(negedge clk);
    iv_a = 0;
    total++; if (ov_a !== 1 || res_a !== 64'd42 || code_a !== 4'b0110)
      $display("FAIL bp_sub_same_edge: ov=%b res=%h code=%b want 1 2a 0110", ov_a, res_a, code_a);
    else pass_cnt++;
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int   r;
    int   bound;
    logic [10:0] list [4] = '{OP_ADD, OP_SUB, OP_AND, OP_ORR};
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      iv_a = ($urandom_range(0, 2) != 0);
      op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) op_b = op_a;
      r = $urandom_range(0, 15);
      if (r < 3)       begin alu_op = 2'b00; opcode = 11'($urandom); end
      else if (r == 3) begin alu_op = 2'b01; opcode = 11'($urandom); end
      else if (r == 4) begin alu_op = 2'b11; opcode = 11'($urandom); end
      else if (r < 13) begin alu_op = 2'b10; opcode = list[$urandom_range(0, 3)]; end
      else if (r == 13) begin alu_op = 2'b10; opcode = 11'($urandom); end
      else if (r == 14) begin alu_op = 2'b10;
        opcode = ($urandom_range(0, 3) == 0) ? OP_MUL : OP_SUB; end
      else begin alu_op = 2'b10; opcode = OP_BAD; end
      #1;
      if (ov_a && out_ready) begin
        if (q.size() == 0) begin
          total++; $display("FAIL rand_unexpected: result %h with empty scoreboard", res_a);
        end else begin
          e = q.pop_front();
          total++; if (res_a !== e.res || code_a !== e.code || ill_a !== e.ill || z_a !== (e.res == 0))
            $display("FAIL rand_result: res=%h code=%b ill=%b z=%b want %h %b %b %b",
                     res_a, code_a, ill_a, z_a, e.res, e.code, e.ill, e.res == 0);
          else pass_cnt++;
        end
      end
      if (iv_a && ir_a) q.push_back(model(alu_op, opcode, op_a, op_b, 64, 1'b1));
      @(negedge clk);
    end
    iv_a = 0; out_ready = 1;
    bound = 0;
    while (q.size() > 0 && bound < 200) begin
      #1;
      if (ov_a) begin
        e = q.pop_front();
        total++; if (res_a !== e.res || code_a !== e.code || ill_a !== e.ill)
          $display("FAIL rand_drain: res=%h code=%b ill=%b want %h %b %b",
                   res_a, code_a, ill_a, e.res, e.code, e.ill);
        else pass_cnt++;
      end
      @(negedge clk);
      bound++;
    end
    total++; if (q.size() != 0) $display("FAIL rand_timeout: %0d results outstanding, want 0", q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sub();
    test_back_to_back();
    test_illegal();
    test_mul8();
    test_backpressure();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
